// File: rtl/bus_width_pack_pkg.sv
// bus_pkg: shared defaults, FSM state type and slot-index width helper for bus_width_pack
package bus_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_RATIO = 4;
    localparam int DEF_CNT_W = $clog2(DEF_RATIO);
    typedef enum logic {S_FILL, S_HOLD} state_t;
    function automatic int cnt_w(input int ratio);
        return $clog2(ratio);
    endfunction
endpackage

// File: rtl/bus_width_pack_ctrl.sv
// bus_pack_ctrl: fill/hold FSM, slot counter and handshakes for bus_width_pack
module bus_pack_ctrl
    import bus_pkg::*;
#(
    parameter int Ratio = DEF_RATIO,
    parameter int CntW  = cnt_w(Ratio)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic            ready_i,
    input  logic            last_i,
    output logic            ready_o,
    output logic            valid_o,
    output logic            acc,
    output logic [CntW-1:0] cnt
);
    state_t state_q, state_d;
    logic [CntW-1:0] cnt_d;
    logic close;
    assign valid_o = state_q == S_HOLD;
    assign ready_o = !valid_o || ready_i;
    assign acc     = valid_i && ready_o;
    always_comb begin
        close   = acc && (cnt == CntW'(Ratio - 1) || last_i);
        state_d = close ? S_HOLD : (acc || (valid_o && ready_i)) ? S_FILL : state_q;
        cnt_d   = close ? '0 : acc ? cnt + 1'b1 : cnt;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FILL;
            cnt     <= '0;
        end else begin
            state_q <= state_d;
            cnt     <= cnt_d;
        end
    end
endmodule

// File: rtl/bus_width_pack.sv
// bus_width_pack: packs Ratio narrow beats into one wide word, little-endian by slot.
// Define BUS_PACK_LAST_EN to add last_i/last_o and allow early-closed partial words.
module bus_width_pack
    import bus_pkg::*;
#(
    parameter int Width = DEF_WIDTH,
    parameter int Ratio = DEF_RATIO
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [Width-1:0]   data_i,
`ifdef BUS_PACK_LAST_EN
    input  logic               last_i,
    output logic               last_o,
`endif
    output logic               valid_o,
    input  logic               ready_i,
    output logic [Width*Ratio-1:0] data_o,
    output logic [Ratio-1:0]   keep_o
);
    localparam int CntW = cnt_w(Ratio);
    logic acc, last_in;
    logic [CntW-1:0] cnt;
`ifdef BUS_PACK_LAST_EN
    assign last_in = last_i;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_o <= 1'b0;
        else if (acc) last_o <= last_i;
    end
`else
    assign last_in = 1'b0;
`endif
    bus_pack_ctrl #(.Ratio(Ratio), .CntW(CntW)) u_ctrl (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_i(ready_i), .last_i(last_in),
        .ready_o(ready_o), .valid_o(valid_o), .acc(acc), .cnt(cnt)
    );
    // a beat landing in slot 0 starts a fresh word, so stale slots are wiped on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_o <= '0;
            keep_o <= '0;
        end else if (acc) begin
            for (int k = 0; k < Ratio; k++) begin
                if (cnt == CntW'(k)) begin
                    data_o[k*Width +: Width] <= data_i;
                    keep_o[k]                <= 1'b1;
                end else if (cnt == '0) begin
                    data_o[k*Width +: Width] <= '0;
                    keep_o[k]                <= 1'b0;
                end
            end
        end
    end
endmodule
